// File: rtl/core_mc.sv
// Multi-cycle 16-bit-instruction core: FETCH -> EXEC (-> MEM) with a latched IR,
// eight-entry register file (r0 hardwired to zero) and simple req/ack memory ports.
module core_mc #(
    parameter int                    P_WORD_LEN  = 16,
    parameter logic [P_WORD_LEN-1:0] P_RST_PC    = '0,
    parameter int                    P_NREG_LOG2 = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_imem_req,
    output logic [P_WORD_LEN-1:0] o_imem_addr,
    input  logic                  i_imem_ack,
    input  logic [15:0]           i_imem_data,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [P_WORD_LEN-1:0] o_dmem_addr,
    output logic [P_WORD_LEN-1:0] o_dmem_wdata,
    input  logic                  i_dmem_ack,
    input  logic [P_WORD_LEN-1:0] i_dmem_rdata,
    output logic                  o_retire,
    output logic                  o_halted
);
    localparam int NREG = 2 ** P_NREG_LOG2;

    // Handshake: a request stays high with address/data stable until the cycle
    // its ack is seen; acks arriving while the request is low are ignored.
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_ADDI, OP_NAND, OP_LUI, OP_SW, OP_LW, OP_BEQ, OP_JALR
    } op_t;

    state_t                  state, state_next;
    logic [P_WORD_LEN-1:0]   pc, pc_next, pc_inc;
    logic [15:0]             ir;
    logic [P_WORD_LEN-1:0]   regs [NREG];

    op_t                     op;
    logic [2:0]              ra_idx, rb_idx, rc_idx;
    logic [P_WORD_LEN-1:0]   ra_val, rb_val, rc_val, simm7, lui_val, mem_addr;

    logic                    ir_load, rf_we;
    logic [P_WORD_LEN-1:0]   rf_wdata;
    logic                    imem_req, dmem_req, dmem_we, retire, halted;
    logic [P_WORD_LEN-1:0]   dmem_addr, dmem_wdata;

    assign op       = op_t'(ir[15:13]);
    assign ra_idx   = ir[12:10];
    assign rb_idx   = ir[9:7];
    assign rc_idx   = ir[2:0];
    assign simm7    = {{(P_WORD_LEN-7){ir[6]}}, ir[6:0]};
    assign lui_val  = {ir[9:0], {(P_WORD_LEN-10){1'b0}}};
    assign ra_val   = (ra_idx == 3'd0) ? '0 : regs[ra_idx];
    assign rb_val   = (rb_idx == 3'd0) ? '0 : regs[rb_idx];
    assign rc_val   = (rc_idx == 3'd0) ? '0 : regs[rc_idx];
    assign pc_inc   = pc + 1'b1;
    assign mem_addr = rb_val + simm7;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_load    = 1'b0;
        rf_we      = 1'b0;
        rf_wdata   = '0;
        retire     = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (i_imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = FETCH;
                pc_next    = pc_inc;
                retire     = 1'b1;
                case (op)
                    OP_ADD:  begin rf_we = 1'b1; rf_wdata = rb_val + rc_val;    end
                    OP_ADDI: begin rf_we = 1'b1; rf_wdata = rb_val + simm7;     end
                    OP_NAND: begin rf_we = 1'b1; rf_wdata = ~(rb_val & rc_val); end
                    OP_LUI:  begin rf_we = 1'b1; rf_wdata = lui_val;            end
                    OP_SW, OP_LW: begin
                        state_next = MEM;
                        pc_next    = pc;
                        retire     = 1'b0;
                    end
                    OP_BEQ: begin
                        if (ra_val == rb_val) pc_next = pc_inc + simm7;
                    end
                    OP_JALR: begin
                        // rB is sampled combinationally before the write lands, so rA==rB works.
                        if (ir[6:0] == 7'd0) begin
                            rf_we    = 1'b1;
                            rf_wdata = pc_inc;
                            pc_next  = rb_val;
                        end else begin
                            state_next = HALT;
                            pc_next    = pc;
                            retire     = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = (op == OP_SW);
                dmem_addr  = mem_addr;
                dmem_wdata = (op == OP_SW) ? ra_val : '0;
                if (i_dmem_ack) begin
                    pc_next    = pc_inc;
                    retire     = 1'b1;
                    state_next = FETCH;
                    if (op == OP_LW) begin
                        rf_we    = 1'b1;
                        rf_wdata = i_dmem_rdata;
                    end
                end
            end
            HALT: halted = 1'b1;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= FETCH;
            pc    <= P_RST_PC;
            ir    <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (ir_load) ir <= i_imem_data;
            if (rf_we && ra_idx != 3'd0) regs[ra_idx] <= rf_wdata;
        end
    end

    // Outputs are forced quiet while reset is held so no access starts mid-reset.
    assign o_imem_req   = imem_req & ~i_rst;
    assign o_imem_addr  = pc;
    assign o_dmem_req   = dmem_req & ~i_rst;
    assign o_dmem_we    = dmem_we & ~i_rst;
    assign o_dmem_addr  = i_rst ? '0 : dmem_addr;
    assign o_dmem_wdata = i_rst ? '0 : dmem_wdata;
    assign o_retire     = retire & ~i_rst;
    assign o_halted     = halted & ~i_rst;
endmodule

// File: doc/core_mc.md
CORE_MC -- requirements
Module: core_mc

Interface
REQ-001 SHALL have parameter P_WORD_LEN, default 16: datapath, register and address width; legal values are 16 or greater.
REQ-002 SHALL have parameter P_RST_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter P_NREG_LOG2, fixed at 3: register index width, giving 8 registers.
REQ-004 SHALL have port i_clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port o_imem_req  out  1  instruction fetch request.
REQ-007 SHALL have port o_imem_addr  out  P_WORD_LEN  fetch address (current PC).
REQ-008 SHALL have port i_imem_ack  in  1  fetch complete; i_imem_data is valid this cycle.
REQ-009 SHALL have port i_imem_data  in  16  instruction word.
REQ-010 SHALL have port o_dmem_req  out  1  data access request.
REQ-011 SHALL have port o_dmem_we  out  1  1=store, 0=load; valid while o_dmem_req is high.
REQ-012 SHALL have port o_dmem_addr  out  P_WORD_LEN  data address.
REQ-013 SHALL have port o_dmem_wdata  out  P_WORD_LEN  store data.
REQ-014 SHALL have port i_dmem_ack  in  1  data access complete; i_dmem_rdata is valid this cycle for loads.
REQ-015 SHALL have port i_dmem_rdata  in  P_WORD_LEN  load data.
REQ-016 SHALL have port o_retire  out  1  one-cycle pulse per completed instruction.
REQ-017 SHALL have port o_halted  out  1  core stopped; held high until reset.

Function
REQ-018 SHALL implement a multi-cycle FSM with states FETCH, EXEC, MEM and HALT, registered in a latched instruction register (IR).
REQ-019 In FETCH, SHALL assert o_imem_req with o_imem_addr=PC held stable until the i_imem_ack cycle; on ack SHALL latch i_imem_data into IR and go to EXEC.
REQ-020 An ack arriving in the same cycle as the request SHALL complete the fetch, so minimum FETCH occupancy is 1 cycle.
REQ-021 SHALL ignore i_imem_ack and i_dmem_ack whenever the corresponding request is low.
REQ-022 Decode: op=IR[15:13]; opcodes 0..7 are ADD, ADDI, NAND, LUI, SW, LW, BEQ, JALR; rA=IR[12:10], rB=IR[9:7], rC=IR[2:0]; imm7=IR[6:0] sign-extended to P_WORD_LEN; imm10=IR[9:0].
REQ-023 ADD, ADDI and NAND SHALL compute rA = rB+rC, rA = rB+simm7 and rA = ~(rB&rC) respectively; arithmetic is modulo 2^P_WORD_LEN with no flags.
REQ-024 LUI SHALL write rA = {imm10, (P_WORD_LEN-10) zeros}.
REQ-025 BEQ SHALL set PC = PC+1+simm7 if rA==rB, else PC+1.
REQ-026 JALR with imm7==0 SHALL write rA=PC+1 and set PC=rB, reading rB before the write, so rA==rB is legal.
REQ-027 JALR with imm7!=0 SHALL enter HALT and assert o_halted without writing any register or changing PC.
REQ-028 Non-memory instructions SHALL complete in EXEC: register write, PC update and o_retire all occur on that single EXEC cycle; next state is FETCH.
REQ-029 SW and LW SHALL go from EXEC to MEM with address = rB+simm7.
REQ-030 SW store data SHALL be rA.
REQ-031 In MEM, o_dmem_req, o_dmem_we, o_dmem_addr and o_dmem_wdata SHALL be held stable until ack.
REQ-032 On the MEM ack cycle, LW SHALL write rA=i_dmem_rdata, PC SHALL become PC+1, o_retire SHALL pulse, and the next state SHALL be FETCH.
REQ-033 With zero-wait memories, latency SHALL be 2 cycles per ALU, branch or JALR instruction and 3 cycles per LW or SW instruction.
REQ-034 Register r0 SHALL read as 0, and writes to r0 SHALL be discarded.
REQ-035 Register reads SHALL be combinational from the register file.
REQ-036 PC SHALL wrap modulo 2^P_WORD_LEN; for example PC=all-ones then +1 gives 0.
REQ-037 o_imem_req and o_dmem_req SHALL never be high in the same cycle.
REQ-038 o_dmem_addr and o_dmem_wdata SHALL be 0 outside MEM.
REQ-039 In HALT, SHALL issue no requests, and o_retire SHALL stay 0.

Reset
REQ-040 While i_rst is high at a clock edge: state=FETCH, PC=P_RST_PC, r1..r7=0, IR=0, and o_imem_req, o_dmem_req, o_dmem_we, o_retire and o_halted all =0.
REQ-041 In the cycle after reset deasserts, SHALL raise o_imem_req with o_imem_addr=P_RST_PC.
REQ-042 Reset during an outstanding FETCH or MEM SHALL abort the access without any register or PC update; a late ack arriving after reset SHALL be ignored.
REQ-043 Reset SHALL clear HALT.

Verification
REQ-044 ADDI r1,r0,-1 then ADD r2,r1,r1 with zero-wait memory -> r1=0xFFFF, r2=0xFFFE; o_retire pulses at cycles 2 and 4 after reset release.
REQ-045 LUI r3,0x3FF; SW r3,0(r0) with 3 wait states on dmem -> r3=0xFFC0; o_dmem_req is high for 4 cycles with addr=0, wdata=0xFFC0 and we=1 held stable.
REQ-046 BEQ r0,r0,-1 at PC=5 -> PC stays 5 repeatedly; BEQ r1,r0,+3 with r1!=0 at PC=5 -> PC=6.
REQ-047 JALR r7,r7 with r7=0x0040 at PC=0x10 -> PC=0x0040 and r7=0x0011; JALR r0,r0,imm=1 -> o_halted=1 and no further requests over 20 cycles.
REQ-048 ADDI r0,r0,5 -> r0 still reads 0.
REQ-049 i_rst pulsed while LW is waiting in MEM, then ack given one cycle later -> rA unchanged, PC=P_RST_PC, fetch restarts at P_RST_PC.
